// File: rtl/sar_logic_ctrl.sv
// SAR sequencer: samples, then resolves NSTEP bits MSB-first by strobing the
// comparator and steering the capacitive-DAC switch pairs from its decisions.
module sar_logic_ctrl #(
  parameter int NSTEP          = 2,
  parameter int SAMPLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic [NSTEP-1:0] data_out,
  output logic             data_valid,
  output logic             cmp_error,
  output logic             ms_sar_clock,
  output logic             ms_sar_sample,
  output logic [NSTEP-1:0] ms_sar_sw,
  output logic [NSTEP-1:0] ms_sar_swb,
  input  logic             ms_sar_dh,
  input  logic             ms_sar_dl,
  input  logic             ms_sar_rdy
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > TIMEOUT_CYCLES) ? SAMPLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int K_W     = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [NSTEP-1:0] ALL_ONES = {NSTEP{1'b1}};
  localparam logic [CNT_W-1:0] SYNC_LAT = CNT_W'(2);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, SAMPLE, CAPTURE, TRIAL, STROBE, RELEASE, DONE
  } state_t;

  state_t           state, state_n;
  logic [K_W-1:0]   k, k_n, k_dec;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       rdy_sync, dh_sync, dl_sync;
  logic             rdy_s, dh_s, dl_s;
  logic             abort;
  logic             busy_n, valid_n, err_n, clock_n, sample_n;
  logic [NSTEP-1:0] data_n, sw_n, swb_n;

  assign rdy_s = rdy_sync[1];
  assign dh_s  = dh_sync[1];
  assign dl_s  = dl_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_sync      <= '0;
      dh_sync       <= '0;
      dl_sync       <= '0;
      state         <= IDLE;
      k             <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      cmp_error     <= 1'b0;
      ms_sar_clock  <= 1'b0;
      ms_sar_sample <= 1'b0;
      ms_sar_sw     <= '0;
      ms_sar_swb    <= ALL_ONES;
    end else begin
      rdy_sync      <= {rdy_sync[0], ms_sar_rdy};
      dh_sync       <= {dh_sync[0], ms_sar_dh};
      dl_sync       <= {dl_sync[0], ms_sar_dl};
      state         <= state_n;
      k             <= k_n;
      cnt           <= cnt_n;
      busy          <= busy_n;
      data_out      <= data_n;
      data_valid    <= valid_n;
      cmp_error     <= err_n;
      ms_sar_clock  <= clock_n;
      ms_sar_sample <= sample_n;
      ms_sar_sw     <= sw_n;
      ms_sar_swb    <= swb_n;
    end
  end

  always_comb begin
    state_n  = state;
    k_n      = k;
    k_dec    = k - K_W'(1);
    cnt_n    = cnt;
    busy_n   = busy;
    data_n   = data_out;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    clock_n  = 1'b0;
    sample_n = 1'b0;
    sw_n     = ms_sar_sw;
    swb_n    = ms_sar_swb;
    abort    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = WAIT_RDY;
          busy_n  = 1'b1;
        end
      end
      WAIT_RDY: begin
        if (rdy_s) begin
          state_n  = SAMPLE;
          sample_n = 1'b1;
          cnt_n    = '0;
          sw_n     = '0;
          swb_n    = ALL_ONES;
        end
      end
      SAMPLE: begin
        sample_n = 1'b1;
        if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_n = CAPTURE;
          clock_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        state_n            = TRIAL;
        k_n                = K_W'(NSTEP - 1);
        sw_n               = '0;
        swb_n              = ALL_ONES;
        sw_n[NSTEP-1]      = 1'b1;
        swb_n[NSTEP-1]     = 1'b0;
      end
      TRIAL: begin
        state_n = STROBE;
        clock_n = 1'b1;
        cnt_n   = '0;
      end
      STROBE: begin
        clock_n = 1'b1;
        // The synchroniser still carries the previous phase for two cycles,
        // so decisions are only trusted once it has seen this strobe.
        if (cnt >= SYNC_LAT && dh_s && dl_s) begin
          abort = 1'b1;
        end else if (cnt >= SYNC_LAT && (dh_s || dl_s)) begin
          state_n = RELEASE;
          clock_n = 1'b0;
          cnt_n   = '0;
          if (dh_s) begin
            sw_n[k]  = 1'b0;
            swb_n[k] = 1'b1;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!dh_s && !dl_s) begin
          if (k == '0) begin
            state_n = DONE;
            data_n  = ms_sar_sw;
            valid_n = 1'b1;
            sw_n    = '0;
            swb_n   = ALL_ONES;
          end else begin
            state_n      = TRIAL;
            k_n          = k_dec;
            sw_n[k_dec]  = 1'b1;
            swb_n[k_dec] = 1'b0;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    if (abort) begin
      state_n = IDLE;
      clock_n = 1'b0;
      sw_n    = '0;
      swb_n   = ALL_ONES;
      err_n   = 1'b1;
      busy_n  = 1'b0;
    end
  end

endmodule
